p19_tinyqv_div: RTL and testbench
=================================

// Module: p19_tinyqv_div
// PURPOSE
//  Nibble-serial 32-bit integer divider for TinyQV, the inverse of the nibble-serial multiplier.
//  Operands arrive 4 bits per cycle, least significant (LS) nibble first, in the same order the ALU and shifter use.
//  Division is restoring, one quotient bit per clock.
//  The selected result (quotient or remainder) leaves as a nibble stream in the same LS-first order.
//  Sits beside the ALU/mul in the execute stage and serves DIV/DIVU/REM/REMU.
// PARAMETERS
//  XLEN  32  operand/result width in bits; must be a multiple of 4 (N = XLEN/4 nibbles)
// PORTS
//  clk      in   1  clock; all state updates on posedge
//  rstn     in   1  asynchronous active-low reset
//  start    in   1  accepted only when busy=0; a/b in that cycle are nibble 0
//  op       in   2  op[1]=1 remainder, 0 quotient; op[0]=1 unsigned, 0 signed (signed needs TINYQV_DIV_SIGNED_EN)
//  a        in   4  dividend nibble, LS first
//  b        in   4  divisor nibble, LS first
//  busy     out  1  block is occupied; start is ignored while high
//  d_valid  out  1  d holds a valid result nibble
//  d        out  4  result nibble, LS first
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, d_valid=0, d=0, all internal registers 0.
//    Reset asserted mid-operation aborts it; no partial output follows.
//  FSM: IDLE -> LOAD -> [PREP] -> CALC -> OUT -> IDLE.
//  IDLE
//    - start=1: capture a/b nibble 0 and latch op; nibble counter=1; go to LOAD.
//  LOAD
//    - Captures nibbles 1..N-1 on consecutive cycles; each nibble shifts in from the top.
//    - After nibble N-1 go to PREP (signed build) or CALC.
//    - a/b are sampled every LOAD cycle; there is no stall.
//  CALC
//    - XLEN cycles. Each cycle:
//      * {rem,quo} <<= 1 with dividend MSB entering rem.
//      * trial = rem - divisor, XLEN+1 bits wide.
//      * If trial is non-negative, rem=trial and quo[0]=1; else quo[0]=0.
//  OUT
//    - N cycles with d_valid=1. Each cycle d = result[3:0] and result shifts right 4.
//    - Return to IDLE after nibble N-1; busy falls the same cycle d_valid falls.
//  busy
//    - 1 from the cycle after the start cycle through the last OUT cycle.
//    - A new start is legal in the first cycle busy=0.
//  Timing (unsigned), with start in cycle 0:
//    - LOAD covers cycles 0..N-1 (cycle 0 is the start capture).
//    - CALC covers N..N+XLEN-1.
//    - d_valid covers N+XLEN..2N+XLEN-1, i.e. cycles 40..47 for XLEN=32.
//  start while busy=1: ignored, with no effect on the operation in flight.
//  Divide by zero:
//    - Quotient is all ones; remainder is the dividend. This falls out of restoring division; no special case.
//  d is registered. d=0 whenever d_valid=0.
// CONFIGURATION
//  TINYQV_DIV_SIGNED_EN defined:
//    - op[0]=0 selects signed.
//    - A one-cycle PREP state after LOAD replaces both operands with their magnitudes.
//    - It records qneg = sa^sb (forced 0 when divisor==0) and rneg = sa.
//    - OUT negates the result serially: invert, then add a carry that starts at 1 on nibble 0 and ripples nibble to nibble.
//    - Signed results:
//      * -2^(XLEN-1) / -1 gives quotient -2^(XLEN-1) and remainder 0.
//      * x / 0 gives quotient -1 and remainder x.
//    - Unsigned ops also pass through PREP with no negation, so latency is uniformly +1 cycle (d_valid cycles 41..48).
//  TINYQV_DIV_SIGNED_EN undefined:
//    - op[0] is ignored and every op is unsigned.
//    - There is no PREP state and no negate logic.
// TESTING
//  1. DIVU 100/7 (op=01) -> q=14, r=2.
//     - d nibbles E,0,0,0,0,0,0,0 in cycles 40..47.
//     - REMU (op=11) gives 2,0,0,0,0,0,0,0.
//  2. DIVU/REMU 0x12345678/0 -> q=0xFFFFFFFF (all F nibbles), r=0x12345678 (nibbles 8,7,6,5,4,3,2,1).
//  3. DIVU 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//     - Assert start again in cycle 5: it is ignored, and the output matches the single operation exactly.
//  4. Signed (macro on) DIV/REM:
//     - -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
//     - 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
//     - d_valid appears in cycles 41..48.
//  5. Signed (macro on) -5/0 -> q=0xFFFFFFFF, r=0xFFFFFFFB.
//     - With the macro off, op=00 behaves as unsigned: 0xFFFFFFFB/0 gives q=0xFFFFFFFF.
//  6. Pulse rstn low in cycle 20 (mid-CALC).
//     - Required: busy=0, d_valid=0, d=0 immediately, and no d_valid afterwards.
//     - A start issued after reset is released completes 100/7 correctly.

Source files
------------

// File: rtl/p19_tinyqv_div_if.sv
// Nibble-serial handshake bundle between the execute stage and the TinyQV divider.
interface p19_tinyqv_div_if;
    logic       start;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       d_valid;
    logic [3:0] d;

    modport master (output start, op, a, b, input busy, d_valid, d);
    modport slave  (input start, op, a, b, output busy, d_valid, d);
endinterface

// File: rtl/p19_tinyqv_div.sv
// Nibble-serial restoring divider for TinyQV (DIV/DIVU/REM/REMU), LS nibble first in and out.
// Signed support is built only when TINYQV_DIV_SIGNED_EN is defined.
module p19_tinyqv_div #(
    parameter int unsigned XLEN = 32
) (
    input logic              clk,
    input logic              rstn,
    p19_tinyqv_div_if.slave  bus
);
    localparam int unsigned N  = XLEN / 4;
    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [CW-1:0] NibLast  = CW'(N - 1);
    localparam logic [CW-1:0] CalcLast = CW'(XLEN - 1);

`ifdef TINYQV_DIV_SIGNED_EN
    typedef enum logic [2:0] {StIdle, StLoad, StPrep, StCalc, StOut} state_e;
`else
    typedef enum logic [2:0] {StIdle, StLoad, StCalc, StOut} state_e;
`endif

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_quo;     // dividend during LOAD/CALC, output shifter during OUT
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic            r_rem_sel;
    logic            r_busy;
    logic            r_dv;
    logic [3:0]      r_d;

    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic            w_fit;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_sel;
    logic [3:0]      w_src;
    logic [3:0]      w_d_nx;

`ifdef TINYQV_DIV_SIGNED_EN
    logic            r_signed;
    logic            r_qneg;
    logic            r_rneg;
    logic            r_carry;
    logic            w_neg;
    logic            w_cin;
    logic [4:0]      w_sum;
    logic            w_c_nx;
`else
    logic            w_unused_op;
    assign w_unused_op = bus.op[0];
`endif

    always_comb begin
        w_shift  = {r_rem, r_quo[XLEN-1]};
        // XLEN+1 bits suffice: the true difference always lies in (-2^XLEN, 2^XLEN).
        w_trial  = w_shift - {1'b0, r_div};
        w_fit    = ~w_trial[XLEN];
        w_rem_nx = w_fit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
        w_quo_nx = {r_quo[XLEN-2:0], w_fit};
        w_sel    = r_rem_sel ? w_rem_nx : w_quo_nx;
        w_src    = (r_state == StOut) ? r_quo[3:0] : w_sel[3:0];
`ifdef TINYQV_DIV_SIGNED_EN
        // Serial two's-complement negate: invert, carry seeded with 1 on nibble 0.
        w_neg    = r_rem_sel ? r_rneg : r_qneg;
        w_cin    = (r_state == StOut) ? r_carry : 1'b1;
        w_sum    = {1'b0, (w_neg ? ~w_src : w_src)} + {4'd0, (w_neg & w_cin)};
        w_d_nx   = w_sum[3:0];
        w_c_nx   = w_sum[4];
`else
        w_d_nx   = w_src;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_rem_sel <= 1'b0;
            r_busy    <= 1'b0;
            r_dv      <= 1'b0;
            r_d       <= 4'd0;
`ifdef TINYQV_DIV_SIGNED_EN
            r_signed  <= 1'b0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_carry   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_quo     <= {bus.a, r_quo[XLEN-1:4]};
                        r_div     <= {bus.b, r_div[XLEN-1:4]};
                        r_rem     <= '0;
                        r_rem_sel <= bus.op[1];
`ifdef TINYQV_DIV_SIGNED_EN
                        r_signed  <= ~bus.op[0];
`endif
                        r_cnt     <= CW'(1);
                        r_busy    <= 1'b1;
                        r_state   <= StLoad;
                    end
                end
                StLoad: begin
                    r_quo <= {bus.a, r_quo[XLEN-1:4]};
                    r_div <= {bus.b, r_div[XLEN-1:4]};
                    if (r_cnt == NibLast) begin
                        r_cnt <= '0;
`ifdef TINYQV_DIV_SIGNED_EN
                        r_state <= StPrep;
`else
                        r_state <= StCalc;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef TINYQV_DIV_SIGNED_EN
                StPrep: begin
                    if (r_signed) begin
                        r_quo  <= r_quo[XLEN-1] ? (~r_quo + 1'b1) : r_quo;
                        r_div  <= r_div[XLEN-1] ? (~r_div + 1'b1) : r_div;
                        r_qneg <= (r_quo[XLEN-1] ^ r_div[XLEN-1]) & (r_div != '0);
                        r_rneg <= r_quo[XLEN-1];
                    end else begin
                        r_qneg <= 1'b0;
                        r_rneg <= 1'b0;
                    end
                    r_state <= StCalc;
                end
`endif
                StCalc: begin
                    r_rem <= w_rem_nx;
                    if (r_cnt == CalcLast) begin
                        // Final step feeds nibble 0 straight into the output register.
                        r_quo   <= {4'd0, w_sel[XLEN-1:4]};
                        r_d     <= w_d_nx;
`ifdef TINYQV_DIV_SIGNED_EN
                        r_carry <= w_c_nx;
`endif
                        r_dv    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= StOut;
                    end else begin
                        r_quo <= w_quo_nx;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                StOut: begin
                    if (r_cnt == NibLast) begin
                        r_dv    <= 1'b0;
                        r_d     <= 4'd0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_d     <= w_d_nx;
`ifdef TINYQV_DIV_SIGNED_EN
                        r_carry <= w_c_nx;
`endif
                        r_quo   <= {4'd0, r_quo[XLEN-1:4]};
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.d_valid = r_dv;
    assign bus.d       = r_d;
endmodule

// File: tb/tb_p19_tinyqv_div.sv
// Scoreboard bench for p19_tinyqv_div: directed cases plus random ops against an arithmetic model.
module tb_p19_tinyqv_div;
    localparam int XLEN = 32;
    localparam int N    = XLEN / 4;
`ifdef TINYQV_DIV_SIGNED_EN
    localparam int LAT  = N + XLEN + 1;
`else
    localparam int LAT  = N + XLEN;
`endif

    typedef struct {
        logic [3:0] nib;
        int         cyc;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    exp_t exp_q[$];

    p19_tinyqv_div_if bus ();

    p19_tinyqv_div #(.XLEN(XLEN)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    // Reference result straight from the arithmetic definition of DIV/DIVU/REM/REMU.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        logic        sgn;
`ifdef TINYQV_DIV_SIGNED_EN
        sgn = ~op[0];
`else
        sgn = 1'b0;
`endif
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $unsigned($signed(a) / $signed(b));
            r = $unsigned($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: pops expected nibbles whenever the DUT presents one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn && bus.d_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_dvalid: got d=%h at cycle %0d, required none", bus.d,
                             cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("d_nibble", {28'd0, bus.d}, {28'd0, e.nib});
                    check("d_cycle", cyc, e.cyc);
                    check("busy_with_dvalid", {31'd0, bus.busy}, 32'd1);
                end
            end else if (rstn && bus.d !== 4'd0) begin
                check("d_zero_when_idle", {28'd0, bus.d}, 32'd0);
            end
        end
    end

    // Called just after a posedge in a cycle where busy=0; returns likewise.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit start5, input bit noise, input int abort_at);
        int          k;
        int          waited;
        logic [31:0] res;
        exp_t        e;
        k = cyc;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a[3:0];
        bus.b     = b[3:0];
        if (abort_at == 0) begin
            res = model(op, a, b);
            for (int i = 0; i < N; i++) begin
                e.nib = res[4*i +: 4];
                e.cyc = k + LAT + i;
                exp_q.push_back(e);
            end
        end
        for (int i = 1; i < N; i++) begin
            @(posedge clk);
            #1;
            bus.start = start5 && (i == 5);
            bus.a     = a[4*i +: 4];
            bus.b     = b[4*i +: 4];
        end
        waited = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (abort_at != 0 && cyc == k + abort_at) begin
                rstn = 1'b0;
                #1;
                check("abort_busy", {31'd0, bus.busy}, 32'd0);
                check("abort_dvalid", {31'd0, bus.d_valid}, 32'd0);
                check("abort_d", {28'd0, bus.d}, 32'd0);
                @(posedge clk);
                #1;
                rstn = 1'b1;
                return;
            end
            if (!bus.busy) break;
            if (noise) begin
                bus.start = ($urandom_range(0, 3) == 0);
                bus.op    = 2'($urandom);
                bus.a     = 4'($urandom);
                bus.b     = 4'($urandom);
            end
            waited++;
            if (waited > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", waited);
                return;
            end
        end
        check("busy_fall_cycle", cyc - k, LAT + N);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        bit          seen;
        n_cmp     = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_dvalid", {31'd0, bus.d_valid}, 32'd0);
        check("reset_d", {28'd0, bus.d}, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        do_op(2'b01, 32'd100, 32'd7, 1'b0, 1'b0, 0);
        do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 0);
        do_op(2'b01, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 0);
        do_op(2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 0);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        do_op(2'b00, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 0);
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 0);

        // Abort mid-CALC, then confirm silence and a clean restart.
        do_op(2'b01, 32'd100, 32'd7, 1'b0, 1'b0, 20);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (bus.d_valid || bus.busy) seen = 1'b1;
        end
        check("post_abort_silent", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
        do_op(2'b01, 32'd100, 32'd7, 1'b0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: rb = {28'd0, 4'($urandom)};
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            do_op(rop, ra, rb, 1'b0, 1'b1, 0);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
